// File: rtl/ex_hazard_ctrl_pkg.sv
// ex_hazard_ctrl_pkg: shared forward encodings, FSM states and register-index defaults for the EX hazard controller.
package ex_hazard_ctrl_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int ZERO_REG = 31;
  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_WB = 2'b01;
  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_e;
endpackage

// File: rtl/ex_hazard_ctrl_fwd_select.sv
// fwd_select: priority forward select for one EX operand; EX/MEM beats WB and XZR never forwards.
module fwd_select #(
  parameter int REG_ADDR_W = ex_hazard_ctrl_pkg::REG_ADDR_W,
  parameter int ZERO_REG = ex_hazard_ctrl_pkg::ZERO_REG
) (
  input  logic [REG_ADDR_W-1:0] src_i,
  input  logic [REG_ADDR_W-1:0] mem_rd_i,
  input  logic                  mem_reg_write_i,
  input  logic [REG_ADDR_W-1:0] wb_rd_i,
  input  logic                  wb_reg_write_i,
  output logic [1:0]            fwd_o
);
  import ex_hazard_ctrl_pkg::*;
  logic live;
  always_comb begin
    live = src_i != REG_ADDR_W'(ZERO_REG);
    fwd_o = (live && mem_reg_write_i && mem_rd_i == src_i) ? FWD_EXMEM :
            (live && wb_reg_write_i && wb_rd_i == src_i) ? FWD_WB : FWD_REGFILE;
  end
endmodule

// File: rtl/ex_hazard_ctrl.sv
// ex_hazard_ctrl: EX forwarding selects, load-use stall and branch flush from a shadow rd/rn/rm pipeline.
// Define EX_HAZARD_PERF_CNT_EN to add the stall_cnt/flush_cnt performance counters.
module ex_hazard_ctrl #(
  parameter int REG_ADDR_W = ex_hazard_ctrl_pkg::REG_ADDR_W,
`ifdef EX_HAZARD_PERF_CNT_EN
  parameter int CNT_W = 32,
`endif
  parameter int ZERO_REG = ex_hazard_ctrl_pkg::ZERO_REG
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rn,
  input  logic [REG_ADDR_W-1:0] id_rm,
  input  logic                  id_uses_rn,
  input  logic                  id_uses_rm,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  branch_taken,
  input  logic                  hold,
  output logic [1:0]            forwardA,
  output logic [1:0]            forwardB,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  id_ex_bubble,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
`ifdef EX_HAZARD_PERF_CNT_EN
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt,
`endif
  output logic                  ex_mem_flush
);
  import ex_hazard_ctrl_pkg::*;
  localparam logic [REG_ADDR_W-1:0] ZR = REG_ADDR_W'(ZERO_REG);
  logic [REG_ADDR_W-1:0] ex_rn_q, ex_rm_q, ex_rd_q, mem_rd_q, wb_rd_q;
  logic ex_rw_q, ex_mr_q, mem_rw_q, wb_rw_q;
  logic lu, flush, kill;
  state_e state_q, state_d;
  always_comb begin
    lu = ex_mr_q && ex_rd_q != ZR &&
         ((id_uses_rn && id_rn == ex_rd_q) || (id_uses_rm && id_rm == ex_rd_q)) &&
         !hold && !branch_taken && state_q == RUN;
    flush = branch_taken && !hold;
    kill = lu || flush;
    pc_write = !hold && !lu;
    if_id_write = !hold && !lu;
    id_ex_bubble = lu;
    if_id_flush = flush;
    id_ex_flush = flush;
    ex_mem_flush = flush;
    state_d = hold ? state_q : (lu ? STALL : RUN);
  end
  always_ff @(posedge clk)
    if (reset) state_q <= RUN;
    else state_q <= state_d;
  // Bubbles park every index on XZR so a killed slot can never match a forward compare.
  always_ff @(posedge clk)
    if (reset) begin
      ex_rn_q <= ZR;
      ex_rm_q <= ZR;
      ex_rd_q <= ZR;
      ex_rw_q <= 1'b0;
      ex_mr_q <= 1'b0;
      mem_rd_q <= ZR;
      mem_rw_q <= 1'b0;
      wb_rd_q <= ZR;
      wb_rw_q <= 1'b0;
    end else if (!hold) begin
      ex_rn_q <= kill ? ZR : id_rn;
      ex_rm_q <= kill ? ZR : id_rm;
      ex_rd_q <= kill ? ZR : id_rd;
      ex_rw_q <= !kill && id_reg_write;
      ex_mr_q <= !kill && id_mem_read;
      mem_rd_q <= flush ? ZR : ex_rd_q;
      mem_rw_q <= !flush && ex_rw_q;
      wb_rd_q <= mem_rd_q;
      wb_rw_q <= mem_rw_q;
    end
  fwd_select #(.REG_ADDR_W(REG_ADDR_W), .ZERO_REG(ZERO_REG)) u_fwd_a (
    .src_i(ex_rn_q), .mem_rd_i(mem_rd_q), .mem_reg_write_i(mem_rw_q),
    .wb_rd_i(wb_rd_q), .wb_reg_write_i(wb_rw_q), .fwd_o(forwardA)
  );
  fwd_select #(.REG_ADDR_W(REG_ADDR_W), .ZERO_REG(ZERO_REG)) u_fwd_b (
    .src_i(ex_rm_q), .mem_rd_i(mem_rd_q), .mem_reg_write_i(mem_rw_q),
    .wb_rd_i(wb_rd_q), .wb_reg_write_i(wb_rw_q), .fwd_o(forwardB)
  );
`ifdef EX_HAZARD_PERF_CNT_EN
  always_ff @(posedge clk)
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + CNT_W'(lu);
      flush_cnt <= flush_cnt + CNT_W'(flush);
    end
`endif
endmodule

// File: doc/ex_hazard_ctrl.md
Name: ex_hazard_ctrl

Overview:
- Sequencing controller for the execute stage. Generates the forwardA/forwardB selects consumed by the execute-stage operand muxes. Also generates the load-use stall and branch-flush controls for the IF/ID, ID/EX and EX/MEM pipeline registers.
- Keeps its own shadow pipeline of register-write metadata (rd, reg_write, mem_read, rn, rm) from ID through WB. The datapath only feeds decode-stage fields plus branch resolution.
- Sits beside the pipeline registers in the top-level CPU.

Parameters:
- REG_ADDR_W, 5, register index width
- ZERO_REG, 31, register index that never forwards or triggers stalls (XZR)
- CNT_W, 32, performance counter width (used only with the optional feature)

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-high
- id_rn  input  REG_ADDR_W  first source register of the instruction in ID
- id_rm  input  REG_ADDR_W  second source register of the instruction in ID
- id_uses_rn  input  1  ID instruction reads rn
- id_uses_rm  input  1  ID instruction reads rm
- id_rd  input  REG_ADDR_W  destination register of the ID instruction
- id_reg_write  input  1  ID instruction writes rd
- id_mem_read  input  1  ID instruction is a load
- branch_taken  input  1  branch in MEM resolved taken
- hold  input  1  global freeze (memory busy)
- forwardA  output  2  ALU input 1 select: 00 regfile, 10 EX/MEM, 01 WB
- forwardB  output  2  ALU input 2 select, same encoding
- pc_write  output  1  PC register load enable
- if_id_write  output  1  IF/ID register load enable
- id_ex_bubble  output  1  load a bubble into ID/EX
- if_id_flush  output  1  clear IF/ID
- id_ex_flush  output  1  clear ID/EX
- ex_mem_flush  output  1  clear EX/MEM

Behaviour:
- Shadow registers:
  - ex_* holds rn, rm, rd, reg_write, mem_read.
  - mem_* holds rd and reg_write.
  - wb_* holds rd and reg_write.
  - All advance on each clk edge unless hold=1; when hold=1 everything keeps its value.
  - A bubble means reg_write=0 and mem_read=0.
- Reset:
  - All shadow valid bits are 0 and the FSM is in RUN.
  - Outputs after reset: forwardA=forwardB=00, pc_write=1, if_id_write=1, and every bubble/flush output is 0.
  - Reset takes priority over hold and branch_taken. Reset during a stall returns to RUN with no pending bubble.
- Forwarding (combinational from shadows, zero latency), for source X in {ex_rn → forwardA, ex_rm → forwardB}:
  - Select 10 if mem_reg_write && mem_rd==X && X!=ZERO_REG.
  - Otherwise select 01 if wb_reg_write && wb_rd==X && X!=ZERO_REG.
  - Otherwise select 00.
  - EX/MEM has priority over WB. Encodings 11 are never driven.
- Load-use detect (lu), asserted when all of the following hold:
  - ex_mem_read and ex_rd!=ZERO_REG;
  - (id_uses_rn && id_rn==ex_rd) || (id_uses_rm && id_rm==ex_rd);
  - hold=0, branch_taken=0, and state is RUN.
- FSM states RUN and STALL:
  - RUN with lu: combinationally drive pc_write=0, if_id_write=0, id_ex_bubble=1. Next edge: ex_* becomes a bubble and state goes to STALL.
  - STALL: outputs are normal and lu is masked. Next edge returns to RUN. Exactly one bubble per load-use.
- branch_taken (hold=0):
  - Drive if_id_flush=id_ex_flush=ex_mem_flush=1 and pc_write=1.
  - Next edge: ex_* and mem_* become bubbles, wb_* takes the current mem_* (the branch itself), and state goes to RUN.
  - Flush overrides a simultaneous load-use. No stall outputs are driven in that cycle.
- hold=1:
  - pc_write=0, if_id_write=0, and all bubble/flush outputs are 0.
  - FSM and shadows frozen. forwardA/B still reflect the frozen shadows.
- Normal advance: ex_* ← id_*, mem_* ← ex_*, wb_* ← mem_*.

Optional Feature:
- Macro: EX_HAZARD_PERF_CNT_EN.
- When defined: adds outputs stall_cnt and flush_cnt (CNT_W each).
  - stall_cnt increments on each cycle where lu is asserted.
  - flush_cnt increments on each cycle where branch_taken && !hold.
  - Both are 0 on reset and wrap modulo 2^CNT_W.
- When undefined: no counter ports or logic.

Decomposition:
- Shared package holds the forward encodings (FWD_REGFILE=2'b00, FWD_EXMEM=2'b10, FWD_WB=2'b01), the FSM state constants, and REG_ADDR_W/ZERO_REG defaults.
- One natural sub-module: fwd_select, the combinational priority compare for one operand. It is instantiated twice (rn→forwardA, rm→forwardB).

Test Plan:
- Back-to-back ALU ops: ADD X1 then SUB X2,X1,X3 → forwardA=10 in the cycle SUB is in EX. With one independent op between them → forwardA=01.
- Double hazard: X1 written in both EX/MEM and WB, consumer reads X1 as rm → forwardB=10 (EX/MEM wins).
- Destination XZR: ADD X31 then a consumer reads X31 → forwardA=forwardB=00, no stall.
- Load-use: LDUR X4 then ADD X5,X4,X6 → one cycle with pc_write=0, if_id_write=0, id_ex_bubble=1. Next cycle shows no stall. When ADD reaches EX, forwardA=01.
- branch_taken=1 in the same cycle as a load-use condition → all three flushes =1, pc_write=1, id_ex_bubble=0. Following cycle: forwardA/B=00 for the flushed slots.
- hold=1 for 3 cycles mid-stall, then reset=1 → outputs frozen during hold. After reset: pc_write=1, forwards 00, FSM in RUN.
